// File: rtl/strobe_pkg.sv
// Shared types for the strobe sequencer: FSM state encoding, segment-table
// entry record and the entry validity rule.
// Entry fields are sized for the widest supported configuration
// (WIDTH <= 64, REP_W <= 32). Unused upper bits are always written as zero.
package strobe_pkg;

    localparam int unsigned PERIOD_MAX_W = 64;
    localparam int unsigned COUNT_MAX_W  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [PERIOD_MAX_W-1:0] period;
        logic [COUNT_MAX_W-1:0]  count;
    } entry_t;

    // A period below 2 or a zero strobe count makes the entry a skip.
    function automatic logic entry_valid(input entry_t e);
        return (e.period >= PERIOD_MAX_W'(2)) && (e.count != '0);
    endfunction

endpackage

// File: rtl/counter_with_strobe.sv
// Reloadable down-counter with a multi-cycle decrement path.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rst             synchronous reload of the count from reset_value
//   enable          issue one decrement (only honoured while ready_c=1)
//   reset_value     reload value (the strobe period)
//   ready_c         no decrement in flight
//   strobe          one-cycle pulse when the count wraps through zero
// A decrement takes LATENCY cycles (LATENCY >= 1); one is in flight at a time.
module counter_with_strobe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] reset_value,
    output logic             ready_c,
    output logic             strobe
);

    localparam int unsigned LAT_W = $clog2(LATENCY + 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_sum;
    logic [LAT_W-1:0] r_wait;
    logic             r_strobe;

    // Decrement issue, latency countdown and write-back with reload on zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_sum    <= '0;
            r_wait   <= '0;
            r_strobe <= 1'b0;
        end else if (rst) begin
            r_count  <= reset_value;
            r_sum    <= '0;
            r_wait   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (r_wait != '0) begin
                r_wait <= r_wait - LAT_W'(1);
                if (r_wait == LAT_W'(1)) begin
                    if (r_sum == '0) begin
                        r_count  <= reset_value;
                        r_strobe <= 1'b1;
                    end else begin
                        r_count <= r_sum;
                    end
                end
            end else if (enable) begin
                r_wait <= LAT_W'(LATENCY);
                r_sum  <= r_count - WIDTH'(1);
            end
        end
    end

    assign ready_c = (r_wait == '0);
    assign strobe  = r_strobe;

endmodule

// File: rtl/strobe_sequencer.sv
// Walks a small flop-based segment table; each entry programs the strobe
// period of one counter and how many strobes make up that segment.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_period/cfg_count   table write port (any cycle)
//   start, stop, loop               sequence control
//   busy, done, seg_idx             sequence status (registered)
//   tick, seg_done                  per-strobe and per-segment pulses (registered)
module strobe_sequencer
    import strobe_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned REP_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]         cfg_period,
    input  logic [REP_W-1:0]         cfg_count,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] seg_idx,
    output logic                     tick,
    output logic                     seg_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t             r_state;
    state_t             w_next;
    entry_t             r_table [DEPTH];
    logic [IDX_W-1:0]   r_seg_idx;
    logic [IDX_W-1:0]   w_seg_idx_nxt;
    logic [WIDTH-1:0]   r_reload;
    logic [REP_W-1:0]   r_cnt;
    logic [REP_W-1:0]   r_tally;
    logic               r_busy;
    logic               r_done;
    logic               r_tick;
    logic               r_seg_done;

    entry_t             w_cur_entry;
    logic               w_cur_valid;
    logic               w_ready;
    logic               w_strobe;
    logic               w_cnt_en;
    logic               w_cnt_rst;
    logic [WIDTH-1:0]   w_reset_value;
    logic               w_hit;
    logic               w_last;

    assign w_cur_entry = r_table[r_seg_idx];
    assign w_cur_valid = entry_valid(w_cur_entry);

    // Reload value follows the table only during LOAD; otherwise the captured copy.
    assign w_reset_value = (r_state == LOAD) ? WIDTH'(w_cur_entry.period) : r_reload;
    assign w_cnt_rst     = (r_state != RUN);

    // A strobe that counts toward the segment; stop wins over it.
    assign w_hit  = (r_state == RUN) && w_strobe && !stop;
    assign w_last = w_hit && (r_tally == (r_cnt - REP_W'(1)));

    // Segment table write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we) begin
            r_table[cfg_addr] <= '{period: PERIOD_MAX_W'(cfg_period),
                                   count:  COUNT_MAX_W'(cfg_count)};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, segment index and counter enable.
    always_comb begin
        w_next        = r_state;
        w_seg_idx_nxt = r_seg_idx;
        w_cnt_en      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next        = LOAD;
                    w_seg_idx_nxt = '0;
                end
            end
            LOAD: begin
                if (stop) begin
                    w_next = IDLE;
                end else if (w_cur_valid) begin
                    w_next = RUN;
                end else begin
                    w_next = NEXT;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next = IDLE;
                end else begin
                    // Stop issuing decrements the moment the last strobe lands.
                    w_cnt_en = w_ready && !w_last;
                    if (w_last) begin
                        w_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (stop) begin
                    w_next = IDLE;
                end else if (r_seg_idx == IDX_W'(DEPTH - 1)) begin
                    if (loop) begin
                        w_next        = LOAD;
                        w_seg_idx_nxt = '0;
                    end else begin
                        w_next = DONE;
                    end
                end else begin
                    w_next        = LOAD;
                    w_seg_idx_nxt = r_seg_idx + IDX_W'(1);
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Segment capture, strobe tally and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_idx  <= '0;
            r_reload   <= '0;
            r_cnt      <= '0;
            r_tally    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tick     <= 1'b0;
            r_seg_done <= 1'b0;
        end else begin
            r_seg_idx  <= w_seg_idx_nxt;
            r_busy     <= (w_next == LOAD) || (w_next == RUN) || (w_next == NEXT);
            r_done     <= (w_next == DONE);
            r_tick     <= w_hit;
            r_seg_done <= w_last;
            if (r_state == LOAD) begin
                r_reload <= WIDTH'(w_cur_entry.period);
                r_cnt    <= REP_W'(w_cur_entry.count);
                r_tally  <= '0;
            end else if (w_hit && (r_tally != r_cnt)) begin
                r_tally <= r_tally + REP_W'(1);
            end
        end
    end

    counter_with_strobe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .rst         (w_cnt_rst),
        .enable      (w_cnt_en),
        .reset_value (w_reset_value),
        .ready_c     (w_ready),
        .strobe      (w_strobe)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign seg_idx  = r_seg_idx;
    assign tick     = r_tick;
    assign seg_done = r_seg_done;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Self-checking bench for strobe_sequencer. Expected behaviour is an ordered
// event list (tick/seg_done per entry, then done) derived from the table model.
module tb_strobe_sequencer;
    import strobe_pkg::*;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = 1;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned REP_W   = 8;
    localparam int unsigned IDX_W   = $clog2(DEPTH);

    localparam int EV_TICK = 16;
    localparam int EV_SEG  = 32;
    localparam int EV_DONE = 48;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_addr = '0;
    logic [WIDTH-1:0] cfg_period = '0;
    logic [REP_W-1:0] cfg_count = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop = 1'b0;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] seg_idx;
    logic             tick;
    logic             seg_done;

    int n_vec = 0;
    int n_err = 0;
    int obs[$];
    int exp_q[$];
    int m_per[DEPTH];
    int m_cnt[DEPTH];
    bit mon_en = 1'b0;
    bit inv_en = 1'b0;
    int n_done = 0;
    logic [WIDTH-1:0] prev_rv = '0;

    strobe_sequencer #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .REP_W   (REP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .busy       (busy),
        .done       (done),
        .seg_idx    (seg_idx),
        .tick       (tick),
        .seg_done   (seg_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int p, input int c);
        cfg_we     = 1'b1;
        cfg_addr   = IDX_W'(a);
        cfg_period = WIDTH'(p);
        cfg_count  = REP_W'(c);
        cyc();
        cfg_we = 1'b0;
        m_per[a] = p;
        m_cnt[a] = c;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_per[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    // One pass over the table as the spec describes it.
    function automatic void add_pass();
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (m_per[i] >= 2 && m_cnt[i] != 0) begin
                for (int k = 0; k < m_cnt[i]; k++) exp_q.push_back(EV_TICK + i);
                exp_q.push_back(EV_SEG + i);
            end
        end
    endfunction

    function automatic int n_sd();
        int n = 0;
        foreach (obs[i]) if ((obs[i] >> 4) == 2) n++;
        return n;
    endfunction

    task automatic compare_events(input string tag, input bit exact);
        int n;
        if (exact) chk({tag, "_nevents"}, obs.size(), exp_q.size());
        else       chk({tag, "_fit"}, int'(obs.size() <= exp_q.size()), 1);
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", tag, i), obs[i], exp_q[i]);
    endtask

    // Single non-looping sequence run against the current model table.
    task automatic run_once(input string tag);
        bit got = 1'b0;
        obs.delete();
        exp_q.delete();
        n_done = 0;
        add_pass();
        exp_q.push_back(EV_DONE);
        mon_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        cyc();
        mon_en = 1'b0;
        chk({tag, "_finished"}, int'(got), 1);
        compare_events(tag, 1'b1);
        @(negedge clk);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_done_pulse"}, int'(done), 0);
    endtask

    // Event recorder plus per-cycle interface invariants.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = dut.w_reset_value;
        end else begin
            if (inv_en) begin
                chk("en_without_ready", int'(dut.w_cnt_en && !dut.w_ready), 0);
                if (dut.w_reset_value != prev_rv)
                    chk("reset_value_change",
                        int'((dut.r_state == LOAD) || (dut.w_strobe && !dut.w_cnt_en)), 1);
                chk("done_while_busy", int'(done && busy), 0);
            end
            prev_rv = dut.w_reset_value;
            if (mon_en) begin
                if (tick)     obs.push_back(EV_TICK + int'(seg_idx));
                if (seg_done) obs.push_back(EV_SEG + int'(seg_idx));
                if (done) begin
                    obs.push_back(EV_DONE);
                    n_done++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        int w;
        bit pulsed;
        model_clear();

        // Reset state.
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_seg_done", int'(seg_done), 0);
        chk("rst_seg_idx", int'(seg_idx), 0);
        chk("rst_cnt_rst", int'(dut.w_cnt_rst), 1);
        chk("rst_cnt_en", int'(dut.w_cnt_en), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_cnt_rst", int'(dut.w_cnt_rst), 1);
        cyc();
        inv_en = 1'b1;

        // Two valid entries, no loop.
        cfg_write(0, 3, 2);
        cfg_write(1, 5, 1);
        run_once("basic");

        // Invalid entries are skipped.
        cfg_write(0, 2, 1);
        cfg_write(1, 1, 2);
        cfg_write(2, 4, 0);
        cfg_write(3, 3, 2);
        run_once("skip");

        // Random tables, including invalid entries.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < int'(DEPTH); i++)
                cfg_write(i, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
            run_once($sformatf("rand%0d", k));
        end

        // Looping sequence, start ignored while busy, then stop.
        cfg_write(0, 2, 1);
        cfg_write(1, 3, 1);
        cfg_write(2, 0, 0);
        cfg_write(3, 1, 1);
        loop = 1'b1;
        obs.delete();
        exp_q.delete();
        for (int p = 0; p < 10; p++) add_pass();
        n_done = 0;
        pulsed = 1'b0;
        mon_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3000 && n_sd() < 6; i++) begin
            if (!pulsed && n_sd() >= 1) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            cyc();
        end
        start = 1'b0;
        chk("loop_reached", int'(n_sd() >= 6), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        @(negedge clk);
        chk("loop_stop_busy", int'(busy), 0);
        sz = obs.size();
        repeat (20) cyc();
        mon_en = 1'b0;
        chk("loop_quiet", obs.size(), sz);
        chk("loop_no_done", n_done, 0);
        compare_events("loop", 1'b0);
        loop = 1'b0;

        // Rewrite of the active entry only shows on the next pass.
        model_clear();
        for (int i = 0; i < int'(DEPTH); i++) cfg_write(i, 0, 0);
        cfg_write(0, 2, 3);
        cfg_write(1, 2, 1);
        loop = 1'b1;
        obs.delete();
        exp_q.delete();
        add_pass();
        m_per[0] = 3;
        m_cnt[0] = 1;
        for (int p = 0; p < 8; p++) add_pass();
        m_per[0] = 2;
        m_cnt[0] = 3;
        n_done = 0;
        mon_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        w = 0;
        while (w < 500 && !(tick && seg_idx == '0)) begin
            cyc();
            w++;
        end
        chk("rewrite_first_tick", int'(w < 500), 1);
        cfg_write(0, 3, 1);
        for (int i = 0; i < 3000 && n_sd() < 4; i++) cyc();
        chk("rewrite_reached", int'(n_sd() >= 4), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        mon_en = 1'b0;
        compare_events("rewrite", 1'b0);
        loop = 1'b0;

        // Asynchronous reset in the middle of a sequence.
        cfg_write(0, 3, 2);
        cfg_write(1, 2, 3);
        cfg_write(2, 4, 1);
        cfg_write(3, 2, 2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (int'($urandom_range(3, 60))) cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_tick", int'(tick), 0);
        chk("mid_rst_seg_done", int'(seg_done), 0);
        chk("mid_rst_seg_idx", int'(seg_idx), 0);
        chk("mid_rst_idle", int'(dut.r_state == IDLE), 1);
        repeat (2) cyc();
        rst_n = 1'b1;
        model_clear();
        cyc();
        run_once("cleared_table");
        cfg_write(0, 3, 2);
        cfg_write(1, 2, 3);
        cfg_write(2, 4, 1);
        cfg_write(3, 2, 2);
        run_once("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
